// File: rtl/gfx_zrenderer_pkg.sv
// Shared types for the z-buffered pixel renderer: FSM states, the FIFO entry
// and the colour-depth helpers.
package gfx_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, ZREAD, CWRITE, ZWRITE} zr_state_e;

  // x/y are zero-extended from PW; depth is stored as a 16-bit lane
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [15:0] z;
    logic [31:0] color;
  } pix_entry_t;

  function automatic logic [2:0] bytes_per_pixel(input logic [1:0] cd);
    case (cd)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] cd);
    case (cd)
      2'b00:   return 4'h1;
      2'b01:   return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/gfx_zrenderer_pixel_fifo.sv
// Pixel FIFO: power-of-two depth, extra pointer bit distinguishes full/empty.
module gfx_pixel_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i)
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= din_i;

endmodule

// File: rtl/gfx_zrenderer.sv
// Z-buffered pixel writer: FIFO-fed FSM issuing aligned colour/depth accesses.
// Optional depth test (ZREAD state) enabled by macro GFX_ZRENDERER_ZTEST_EN.
module gfx_zrenderer
  import gfx_pkg::*;
#(
  parameter int MDW = 256,
  parameter int PFD = 8,
  parameter int PW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      target_base_i,
  input  logic [31:0]      zbuffer_base_i,
  input  logic [PW-1:0]    target_size_x_i,
  input  logic [PW-1:0]    target_size_y_i,
  input  logic [1:0]       color_depth_i,
  input  logic             zbuffer_enable_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PW-1:0]    pixel_x_i,
  input  logic [PW-1:0]    pixel_y_i,
  input  logic [PW-1:0]    pixel_z_i,
  input  logic [31:0]      color_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [MDW/8-1:0] mem_sel_o,
  output logic [MDW-1:0]   mem_dat_o,
  input  logic [MDW-1:0]   mem_dat_i,
  input  logic             mem_ack_i,
  output logic             done_o,
  output logic             busy_o,
  output logic [15:0]      clip_cnt_o,
  output logic [15:0]      zfail_cnt_o
);
  localparam int SELW = MDW/8;
  localparam int LB   = $clog2(SELW);

  zr_state_e  state_q, state_d;
  pix_entry_t fifo_din, fifo_dout, wpix;
  logic       fifo_full, fifo_empty, fifo_pop;

  logic          zen_q;
  logic [31:0]   tbase_q, zbase_q;
  logic [PW-1:0] sx_q, sy_q;
  logic [1:0]    cdep_q;

  assign fifo_din    = '{x: 32'(pixel_x_i), y: 32'(pixel_y_i), z: 16'(pixel_z_i), color: color_i};
  assign pix_ready_o = ~fifo_full;
  assign fifo_pop    = (state_q == IDLE) && !fifo_empty;
  assign busy_o      = !fifo_empty || (state_q != IDLE);

  gfx_pixel_fifo #(.DEPTH(PFD), .T(pix_entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pix_valid_i),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Address path: offsets are computed in ADDR and kept for the later states
  logic             clipped, ack, zpass, issue;
  logic [31:0]      pix_idx, c_addr_n, z_addr_n, c_addr_q, z_addr_q, c_addr, z_addr;
  logic [SELW-1:0]  c_sel, z_sel;
  logic [31:0]      col32;
  logic [MDW-1:0]   c_dat, z_dat;
  zr_state_e        req_st;

  assign clipped  = (wpix.x >= 32'(sx_q)) || (wpix.y >= 32'(sy_q));
  assign pix_idx  = wpix.y * 32'(sx_q) + wpix.x;
  assign c_addr_n = tbase_q + pix_idx * 32'(bytes_per_pixel(cdep_q));
  assign z_addr_n = zbase_q + (pix_idx << 1);
  assign c_addr   = (state_q == ADDR) ? c_addr_n : c_addr_q;
  assign z_addr   = (state_q == ADDR) ? z_addr_n : z_addr_q;

  assign c_sel = {{(SELW-4){1'b0}}, byte_mask(cdep_q)} << c_addr[LB-1:0];
  assign z_sel = {{(SELW-2){1'b0}}, 2'b11} << z_addr[LB-1:0];
  assign col32 = (cdep_q == 2'b00) ? {4{wpix.color[7:0]}} :
                 (cdep_q == 2'b01) ? {2{wpix.color[15:0]}} : wpix.color;
  assign c_dat = {(MDW/32){col32}};
  assign z_dat = {(MDW/16){wpix.z}};

  assign ack    = mem_req_o & mem_ack_i;
  // A request state issues whenever the bus is idle; leaving ADDR issues at once
  assign issue  = !mem_req_o && ((state_q == ADDR) ? !clipped : (state_q != IDLE));
  assign req_st = (state_q == ADDR) ? state_d : state_q;

`ifdef GFX_ZRENDERER_ZTEST_EN
  assign zpass = wpix.z < mem_dat_i[{z_addr_q[LB-1:0], 3'b000} +: 16];
`else
  logic unused_rdata;
  assign zpass        = 1'b1;
  assign unused_rdata = ^mem_dat_i;
  assign zfail_cnt_o  = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fifo_pop) state_d = ADDR;
      ADDR: begin
        if (clipped)    state_d = IDLE;
`ifdef GFX_ZRENDERER_ZTEST_EN
        else if (zen_q) state_d = ZREAD;
`endif
        else            state_d = CWRITE;
      end
      ZREAD:  if (ack) state_d = zpass ? CWRITE : IDLE;
      CWRITE: if (ack) state_d = zen_q ? ZWRITE : IDLE;
      ZWRITE: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wpix       <= '0;
      zen_q      <= 1'b0;
      tbase_q    <= '0;
      zbase_q    <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      cdep_q     <= '0;
      c_addr_q   <= '0;
      z_addr_q   <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= '0;
      mem_dat_o  <= '0;
      done_o     <= 1'b0;
      clip_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      if (fifo_pop) begin
        wpix    <= fifo_dout;
        zen_q   <= zbuffer_enable_i;
        tbase_q <= target_base_i;
        zbase_q <= zbuffer_base_i;
        sx_q    <= target_size_x_i;
        sy_q    <= target_size_y_i;
        cdep_q  <= color_depth_i;
      end
      if (state_q == ADDR) begin
        c_addr_q <= c_addr_n;
        z_addr_q <= z_addr_n;
        if (clipped) begin
          done_o <= 1'b1;
          if (clip_cnt_o != 16'hFFFF) clip_cnt_o <= clip_cnt_o + 16'd1;
        end
      end
      if (ack && state_d == IDLE) done_o <= 1'b1;

      if (ack) mem_req_o <= 1'b0;
      else if (issue) begin
        mem_req_o <= 1'b1;
        case (req_st)
          ZREAD: begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= {z_addr[31:LB], {LB{1'b0}}};
            mem_sel_o  <= z_sel;
            mem_dat_o  <= '0;
          end
          ZWRITE: begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= {z_addr[31:LB], {LB{1'b0}}};
            mem_sel_o  <= z_sel;
            mem_dat_o  <= z_dat;
          end
          default: begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= {c_addr[31:LB], {LB{1'b0}}};
            mem_sel_o  <= c_sel;
            mem_dat_o  <= c_dat;
          end
        endcase
      end
    end
  end

`ifdef GFX_ZRENDERER_ZTEST_EN
  logic [15:0] zfail_q;
  assign zfail_cnt_o = zfail_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) zfail_q <= '0;
    else if (state_q == ZREAD && ack && !zpass && zfail_q != 16'hFFFF)
      zfail_q <= zfail_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gfx_zrenderer.sv
// Directed bench for gfx_zrenderer (MDW=256, PFD=8): addressing, clipping,
// depth handling, FIFO back-pressure and mid-transaction reset.
module tb_gfx_zrenderer;
  logic         clk = 1'b0;
  logic         rst_ni;
  logic [31:0]  target_base, zbuffer_base;
  logic [15:0]  size_x, size_y;
  logic [1:0]   color_depth;
  logic         zen;
  logic         pix_valid, pix_ready;
  logic [15:0]  pixel_x, pixel_y, pixel_z;
  logic [31:0]  color;
  logic         mem_req, mem_we, mem_ack, done, busy;
  logic [31:0]  mem_addr, mem_sel;
  logic [255:0] mem_dat_o, mem_dat_i;
  logic [15:0]  clip_cnt, zfail_cnt;
  logic         ack_en;
  logic [15:0]  zstore;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } rec_t;
  rec_t log_q[$];
  int   done_cnt, req_cycles;
  int   n_assert, n_fail;

  always #5 clk = ~clk;

  gfx_zrenderer #(.MDW(256), .PFD(8), .PW(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .target_base_i(target_base), .zbuffer_base_i(zbuffer_base),
    .target_size_x_i(size_x), .target_size_y_i(size_y),
    .color_depth_i(color_depth), .zbuffer_enable_i(zen),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .pixel_z_i(pixel_z), .color_i(color),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_sel_o(mem_sel), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mem_ack), .done_o(done), .busy_o(busy),
    .clip_cnt_o(clip_cnt), .zfail_cnt_o(zfail_cnt)
  );

  // Zero-wait memory when enabled; reads return the stored depth in every lane
  assign mem_ack   = mem_req & ack_en;
  assign mem_dat_i = {16{zstore}};

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (mem_req) req_cycles++;
    if (mem_req && mem_ack) log_q.push_back('{mem_we, mem_addr, mem_sel, mem_dat_o});
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic [31:0] c);
    @(negedge clk);
    pixel_x = x; pixel_y = y; pixel_z = z; color = c; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int start;
    start = done_cnt;
    for (int k = 0; k < 300 && done_cnt < start + n; k++) @(negedge clk);
    chk(tag, 256'(done_cnt - start), 256'(n));
  endtask

  initial begin
    int d0, r0;
    rst_ni = 1'b0; pix_valid = 1'b0; ack_en = 1'b1; zstore = 16'h0100;
    target_base = 32'h1000; zbuffer_base = 32'h8000;
    size_x = 16'd640; size_y = 16'd480; color_depth = 2'b01; zen = 1'b0;
    pixel_x = '0; pixel_y = '0; pixel_z = '0; color = '0;
    done_cnt = 0; req_cycles = 0; n_assert = 0; n_fail = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", pix_ready, 1); chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_sel", mem_sel, 0);
    chk("rst_clip", clip_cnt, 0);   chk("rst_zfail", zfail_cnt, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // 16bpp (3,1): offset 1286 -> 0x1506, line 0x1500, bytes 7:6
    push(16'd3, 16'd1, 16'd0, 32'h0000ABCD);
    @(negedge clk);
    @(negedge clk);
    chk("a_req", mem_req, 1); chk("a_we", mem_we, 1);
    chk("a_addr", mem_addr, 32'h1500); chk("a_sel", mem_sel, 32'h0000_00C0);
    chk("a_dat", mem_dat_o, {16{16'hABCD}}); chk("a_done_early", done, 0);
    @(negedge clk);
    chk("a_done", done, 1); chk("a_req_drop", mem_req, 0);
    @(negedge clk);
    chk("a_done_pulse", done, 0); chk("a_busy", busy, 0);

    // 8bpp (5,0): byte 5 of line 0x1000
    log_q.delete(); color_depth = 2'b00;
    push(16'd5, 16'd0, 16'd0, 32'h00000012);
    wait_done(1, "b8_done");
    chk("b8_n", log_q.size(), 1); chk("b8_addr", log_q[0].addr, 32'h1000);
    chk("b8_sel", log_q[0].sel, 32'h20); chk("b8_dat", log_q[0].dat, {32{8'h12}});

    // 32bpp (3,0): bytes 15:12
    log_q.delete(); color_depth = 2'b10;
    push(16'd3, 16'd0, 16'd0, 32'hDEADBEEF);
    wait_done(1, "b32_done");
    chk("b32_addr", log_q[0].addr, 32'h1000); chk("b32_sel", log_q[0].sel, 32'h0000_F000);
    chk("b32_dat", log_q[0].dat, {8{32'hDEADBEEF}});

    // Last in-bounds pixel (639,479) at 16bpp: 0x96FFE -> line 0x96FE0, bytes 31:30
    log_q.delete(); color_depth = 2'b01;
    push(16'd639, 16'd479, 16'd0, 32'h00001234);
    wait_done(1, "edge_done");
    chk("edge_addr", log_q[0].addr, 32'h0009_6FE0); chk("edge_sel", log_q[0].sel, 32'hC000_0000);

    // Clipping on x and on y
    r0 = req_cycles;
    push(16'd640, 16'd0, 16'd0, 32'h1);
    wait_done(1, "clipx_done");
    chk("clipx_noreq", 256'(req_cycles - r0), 0); chk("clipx_cnt", clip_cnt, 1);
    push(16'd0, 16'd480, 16'd0, 32'h1);
    wait_done(1, "clipy_done");
    chk("clipy_noreq", 256'(req_cycles - r0), 0); chk("clipy_cnt", clip_cnt, 2);

    // Depth buffering, z line 0x8000+0x506 -> 0x8500
    zen = 1'b1; log_q.delete();
    push(16'd3, 16'd1, 16'h00FF, 32'h0000ABCD);
    wait_done(1, "z1_done");
`ifdef GFX_ZRENDERER_ZTEST_EN
    chk("z1_n", log_q.size(), 3);
    chk("z1_rd_we", log_q[0].we, 0); chk("z1_rd_addr", log_q[0].addr, 32'h8500);
    chk("z1_rd_sel", log_q[0].sel, 32'hC0);
    chk("z1_cw_addr", log_q[1].addr, 32'h1500);
    chk("z1_zw_we", log_q[2].we, 1); chk("z1_zw_addr", log_q[2].addr, 32'h8500);
    chk("z1_zw_dat", log_q[2].dat, {16{16'h00FF}});
    log_q.delete();
    push(16'd3, 16'd1, 16'h0100, 32'h0000ABCD);
    wait_done(1, "z2_done");
    chk("z2_n", log_q.size(), 1); chk("z2_rd_we", log_q[0].we, 0);
    chk("z2_zfail", zfail_cnt, 1);
`else
    chk("z1_n", log_q.size(), 2);
    chk("z1_cw_we", log_q[0].we, 1); chk("z1_cw_addr", log_q[0].addr, 32'h1500);
    chk("z1_zw_we", log_q[1].we, 1); chk("z1_zw_addr", log_q[1].addr, 32'h8500);
    chk("z1_zw_sel", log_q[1].sel, 32'hC0); chk("z1_zw_dat", log_q[1].dat, {16{16'h00FF}});
    chk("z1_zfail", zfail_cnt, 0);
`endif
    zen = 1'b0;

    // Back-pressure: 9 pushes with acks stalled -> 1 in flight + 8 queued
    ack_en = 1'b0; log_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pixel_x = 16'(i); pixel_y = 16'd2; color = 32'h100 + 32'(i); pix_valid = 1'b1;
    end
    @(negedge clk);
    chk("fill_ready", pix_ready, 0);
    pixel_x = 16'd99; color = 32'h999;
    repeat (3) @(negedge clk);
    pix_valid = 1'b0;
    chk("fill_ready_hold", pix_ready, 0); chk("fill_stall_req", mem_req, 1);
    chk("fill_busy", busy, 1); chk("fill_no_done", 256'(done_cnt - d0), 0);
    ack_en = 1'b1;
    wait_done(9, "fill_done");
    chk("fill_n", log_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill_sel%0d", i), log_q[i].sel, 32'h3 << (2*i));
      chk($sformatf("fill_col%0d", i), log_q[i].dat[15:0], 16'h100 + 16'(i));
    end
    repeat (3) @(negedge clk);
    chk("fill_idle", busy, 0); chk("fill_ready_back", pix_ready, 1);

    // Reset during a stalled colour write with a second pixel queued
    ack_en = 1'b0; log_q.delete();
    push(16'd1, 16'd0, 16'd0, 32'h55);
    push(16'd2, 16'd0, 16'd0, 32'h66);
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    chk("rs_pre_req", mem_req, 1); chk("rs_pre_we", mem_we, 1);
    rst_ni = 1'b0;
    #1;
    chk("rs_req", mem_req, 0); chk("rs_busy", busy, 0);
    chk("rs_ready", pix_ready, 1); chk("rs_clip", clip_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1; ack_en = 1'b1; d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("rs_no_write", log_q.size(), 0); chk("rs_no_done", 256'(done_cnt - d0), 0);
    chk("rs_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
